// File: rtl/bit_loc_pkg.sv
// Constants and types shared between the bit-location stage and its histogram consumer.
package bit_loc_pkg;

  localparam int unsigned IDX_W     = 3;
  localparam int unsigned NUM_BINS  = 2 ** IDX_W;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } hist_state_t;

endpackage

// File: rtl/bit_index_histogram_if.sv
// Index stream from the bit-location stage plus the bin report stream to the sink.
interface bit_index_histogram_if #(
  parameter int unsigned CNT_W = bit_loc_pkg::CNT_W_DEF
);

  logic                          vld_src;
  logic [bit_loc_pkg::IDX_W-1:0] index_in;
  logic                          rdy_src;
  logic                          vld_sink;
  logic [bit_loc_pkg::IDX_W-1:0] bin_id;
  logic [CNT_W-1:0]              bin_cnt;
  logic                          bin_sat;
  logic                          last;
  logic                          rdy_sink;

  modport slave (
    input  vld_src, index_in, rdy_sink,
    output rdy_src, vld_sink, bin_id, bin_cnt, bin_sat, last
  );

  modport master (
    output vld_src, index_in, rdy_sink,
    input  rdy_src, vld_sink, bin_id, bin_cnt, bin_sat, last
  );

endinterface

// File: rtl/bit_index_histogram_sat_counter.sv
// Single histogram bin: saturating up-counter with clear and a sticky saturation flag.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc_i) begin
      // A dropped increment marks the bin as saturated for the rest of the frame.
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/bit_index_histogram.sv
// Per-frame histogram of bit indices; drains every bin to the sink after FRAME_LEN accepts.
module bit_index_histogram
  import bit_loc_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned FRAME_LEN = 16
) (
  input logic                   clk,
  input logic                   rst,
  bit_index_histogram_if.slave  bus
);

  localparam int unsigned       SMP_W   = $clog2(FRAME_LEN + 1);
  localparam logic [SMP_W-1:0]  LastSmp = SMP_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  LastBin = IDX_W'(NUM_BINS - 1);

  hist_state_t        state_q, state_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_BINS-1:0] inc, clr, sat;
  logic [CNT_W-1:0]   cnt [NUM_BINS];
  logic               report, accept, handshake;

  assign report    = (state_q == DRAIN);
  assign accept    = bus.vld_src & bus.rdy_src;
  assign handshake = report & bus.rdy_sink;

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    ptr_d   = ptr_q;
    inc     = '0;
    clr     = '0;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          inc[bus.index_in] = 1'b1;
          if (smp_q == LastSmp) begin
            smp_d   = '0;
            state_d = DRAIN;
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (handshake) begin
          clr[ptr_q] = 1'b1;
          // NUM_BINS is a power of two, so the pointer wraps to 0 on the last bin.
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LastBin) state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      smp_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      ptr_q   <= ptr_d;
    end
  end

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_bin (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc[g]),
      .clr_i (clr[g]),
      .cnt_o (cnt[g]),
      .sat_o (sat[g])
    );
  end

  assign bus.rdy_src  = (state_q == ACCUM) & ~rst;
  assign bus.vld_sink = report;
  assign bus.bin_id   = report ? ptr_q : '0;
  assign bus.bin_cnt  = report ? cnt[ptr_q] : '0;
  assign bus.bin_sat  = report & sat[ptr_q];
  assign bus.last     = report & (ptr_q == LastBin);

endmodule

// File: tb/tb_bit_index_histogram.sv
// Directed bench for bit_index_histogram: default instance plus a CNT_W=4/FRAME_LEN=20 instance.
module tb_bit_index_histogram;
  import bit_loc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  int   cur_sel = 0;
  logic cur_vld = 1'b0;
  int   cur_idx = 0;
  logic cur_rs  = 1'b1;

  always #5 clk = ~clk;

  bit_index_histogram_if #(.CNT_W(8)) busa ();
  bit_index_histogram_if #(.CNT_W(4)) busb ();

  bit_index_histogram #(
    .CNT_W     (8),
    .FRAME_LEN (16)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (busa)
  );

  bit_index_histogram #(
    .CNT_W     (4),
    .FRAME_LEN (20)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (busb)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    busa.vld_src  = (cur_sel == 0) & cur_vld;
    busa.index_in = IDX_W'(cur_idx);
    busa.rdy_sink = (cur_sel == 0) ? cur_rs : 1'b1;
    busb.vld_src  = (cur_sel == 1) & cur_vld;
    busb.index_in = IDX_W'(cur_idx);
    busb.rdy_sink = (cur_sel == 1) ? cur_rs : 1'b1;
  endtask

  task automatic smp(input int sel, output int v, output int r, output int id, output int c,
                     output int s, output int l);
    if (sel == 0) begin
      v = int'(busa.vld_sink); r = int'(busa.rdy_src); id = int'(busa.bin_id);
      c = int'(busa.bin_cnt);  s = int'(busa.bin_sat); l = int'(busa.last);
    end else begin
      v = int'(busb.vld_sink); r = int'(busb.rdy_src); id = int'(busb.bin_id);
      c = int'(busb.bin_cnt);  s = int'(busb.bin_sat); l = int'(busb.last);
    end
  endtask

  // One accepted sample, optionally preceded by idle cycles; bounded wait on rdy_src.
  task automatic feed(input int sel, input int idx, input int gap);
    int v, r, id, c, s, l;
    bit acc;
    int cyc;
    acc = 1'b0;
    cyc = 0;
    cur_sel = sel;
    repeat (gap) begin
      @(negedge clk);
      cur_vld = 1'b0;
      apply();
    end
    while (!acc && cyc < 40) begin
      @(negedge clk);
      cur_vld = 1'b1;
      cur_idx = idx;
      apply();
      #1;
      smp(sel, v, r, id, c, s, l);
      @(posedge clk);
      acc = (r == 1);
      cyc++;
    end
    if (!acc) check("feed_timeout", 0, 1);
  endtask

  task automatic drain(input int sel, input int exp_c[8], input int exp_s[8], input bit toggle,
                       input int stop_at, output int sum);
    int v, r, id, c, s, l;
    int k, cyc;
    bit rs;
    k   = 0;
    cyc = 0;
    sum = 0;
    cur_sel = sel;
    while (k < stop_at && cyc < 64) begin
      @(negedge clk);
      smp(sel, v, r, id, c, s, l);
      if (cyc == 0) check("first_rpt_lat", v, 1);
      if (v == 1) begin
        check("drain_rdy_src", r, 0);
        check("bin_id", id, k);
        check("bin_cnt", c, exp_c[k]);
        check("bin_sat", s, exp_s[k]);
        check("last", l, (k == 7) ? 1 : 0);
      end
      rs = toggle ? (cyc % 2 == 0) : 1'b1;
      if (v == 1 && rs) begin
        sum += c;
        k++;
      end
      cur_rs = rs;
      apply();
      cyc++;
    end
    check("drain_reports", k, stop_at);
    if (stop_at == 8) begin
      @(negedge clk);
      smp(sel, v, r, id, c, s, l);
      check("post_vld_sink", v, 0);
      check("post_rdy_src", r, 1);
      cur_vld = 1'b0;
      cur_rs  = 1'b1;
      apply();
    end
  endtask

  task automatic do_reset(input int sel);
    int v, r, id, c, s, l;
    @(negedge clk);
    rst     = 1'b1;
    cur_vld = 1'b0;
    cur_rs  = 1'b1;
    apply();
    @(negedge clk);
    smp(sel, v, r, id, c, s, l);
    check("rst_vld_sink", v, 0);
    check("rst_rdy_src", r, 0);
    check("rst_bin_id", id, 0);
    check("rst_bin_cnt", c, 0);
    check("rst_last", l, 0);
    rst = 1'b0;
    @(negedge clk);
    smp(sel, v, r, id, c, s, l);
    check("rel_rdy_src", r, 1);
    check("rel_vld_sink", v, 0);
  endtask

  initial begin
    int e[8];
    int z[8];
    int es[8];
    int sum;
    int idx;
    int v, r, id, c, s, l;

    foreach (z[i]) z[i] = 0;
    apply();
    repeat (2) @(negedge clk);
    smp(0, v, r, id, c, s, l);
    check("init_rdy_src", r, 0);
    check("init_vld_sink", v, 0);
    check("init_bin_sat", s, 0);
    do_reset(0);

    // Frame of 16 x index 3, vld_src kept high into the drain.
    repeat (16) feed(0, 3, 0);
    foreach (e[i]) e[i] = 0;
    e[3] = 16;
    drain(0, e, z, 1'b0, 8, sum);

    // Indices 0..7 twice, sink stalling every other cycle.
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < 8; i++) feed(0, i, 0);
    foreach (e[i]) e[i] = 2;
    drain(0, e, z, 1'b1, 8, sum);

    // Narrow instance: saturation, then a fresh frame proves bins clear on drain.
    repeat (20) feed(1, 5, 0);
    foreach (e[i]) e[i] = 0;
    foreach (es[i]) es[i] = 0;
    e[5] = 15;
    es[5] = 1;
    drain(1, e, es, 1'b0, 8, sum);
    repeat (16) feed(1, 5, 0);
    repeat (4) feed(1, 0, 0);
    e[0] = 4;
    drain(1, e, es, 1'b0, 8, sum);

    // Reset mid-frame discards the partial frame.
    repeat (9) feed(0, 6, 0);
    do_reset(0);
    repeat (16) feed(0, 1, 0);
    foreach (e[i]) e[i] = 0;
    e[1] = 16;
    drain(0, e, z, 1'b0, 8, sum);
    check("sum_after_rst", sum, 16);

    // Reset while bin 4 is being presented.
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < 8; i++) feed(0, i, 0);
    foreach (e[i]) e[i] = 2;
    drain(0, e, z, 1'b0, 4, sum);
    @(negedge clk);
    smp(0, v, r, id, c, s, l);
    check("pre_rst_bin_id", id, 4);
    check("pre_rst_vld", v, 1);
    rst     = 1'b1;
    cur_vld = 1'b0;
    cur_rs  = 1'b1;
    apply();
    @(negedge clk);
    smp(0, v, r, id, c, s, l);
    check("drain_rst_vld_sink", v, 0);
    check("drain_rst_rdy_src", r, 0);
    rst = 1'b0;
    repeat (16) feed(0, 7, 0);
    foreach (e[i]) e[i] = 0;
    e[7] = 16;
    drain(0, e, z, 1'b0, 8, sum);

    // Back-to-back random frames against a counting model.
    for (int f = 0; f < 3; f++) begin
      foreach (e[i]) e[i] = 0;
      for (int n = 0; n < 16; n++) begin
        idx = $urandom_range(7);
        feed(0, idx, $urandom_range(2));
        e[idx]++;
      end
      drain(0, e, z, f[0], 8, sum);
      check("rand_sum", sum, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
